// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared states and byte constants
// for the GMII receive framer.
package eth_rx_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t IDLE     = 2'd0;
  localparam rx_state_t PREAMBLE = 2'd1;
  localparam rx_state_t PAYLOAD  = 2'd2;
  localparam rx_state_t DROP     = 2'd3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int DEF_MIN_PRE = 7;
  localparam int DEF_MAX_PRE = 15;

endpackage

// File: rtl/rx_hold_stage.sv
// rx_hold_stage: one-byte hold register plus
// output flop; builds pl_* with sof/eof/err.
module rx_hold_stage (
  input  logic       rx_clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       flush,
  input  logic       first,
  input  logic       err,
  input  logic [7:0] data,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_sof,
  output logic       pl_eof,
  output logic       pl_err
);

  logic [7:0] hold_data;
  logic       hold_full;
  logic       hold_first;
  logic       sticky;

  // Release the held byte on the next push, or as eof on flush.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      hold_first <= 1'b0;
      sticky     <= 1'b0;
      pl_data    <= '0;
      pl_valid   <= 1'b0;
      pl_sof     <= 1'b0;
      pl_eof     <= 1'b0;
      pl_err     <= 1'b0;
    end else begin
      pl_valid <= 1'b0;
      pl_sof   <= 1'b0;
      pl_eof   <= 1'b0;
      pl_err   <= 1'b0;
      if (flush) begin
        if (hold_full) begin
          pl_data  <= hold_data;
          pl_valid <= 1'b1;
          pl_sof   <= hold_first;
          pl_eof   <= 1'b1;
          pl_err   <= sticky | err;
        end
        hold_full <= 1'b0;
        sticky    <= 1'b0;
      end else if (push) begin
        if (hold_full) begin
          pl_data  <= hold_data;
          pl_valid <= 1'b1;
          pl_sof   <= hold_first;
        end
        hold_data  <= data;
        hold_full  <= 1'b1;
        hold_first <= first;
        sticky     <= sticky | err;
      end else if (err) begin
        sticky <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_sfd_framer.sv
// rx_sfd_framer: strips preamble/SFD, frames payload.
// RX_STRICT_PREAMBLE_EN enables strict preamble checks.
module rx_sfd_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_PRE   = DEF_MIN_PRE,
  parameter int MAX_PRE   = DEF_MAX_PRE,
  parameter int MAX_FRAME = 1522,
  parameter int PRE_CNT_W = 5,
  parameter int LEN_W     = 11
) (
  input  logic                 rx_clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_enable,
  input  logic                 rx_error,
  output logic                 sfd_wait,
  output logic [7:0]           pl_data,
  output logic                 pl_valid,
  output logic                 pl_sof,
  output logic                 pl_eof,
  output logic                 pl_err,
  output logic [PRE_CNT_W-1:0] pre_len,
  output logic                 pre_err
);

`ifdef RX_STRICT_PREAMBLE_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam logic [PRE_CNT_W-1:0] PRE_SAT =
    PRE_CNT_W'(MAX_PRE + 1);
  localparam logic [PRE_CNT_W-1:0] PRE_LO =
    PRE_CNT_W'(MIN_PRE);
  localparam logic [PRE_CNT_W-1:0] PRE_HI =
    PRE_CNT_W'(MAX_PRE);
  localparam logic [LEN_W-1:0] LEN_MAX =
    LEN_W'(MAX_FRAME);

  rx_state_t            state, state_n;
  logic [PRE_CNT_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0]     len, len_n;
  logic                 push, flush, first, err;
  logic                 perr, take, pre_ok;
  logic                 push_q, flush_q;
  logic                 first_q, err_q;
  logic [7:0]           data_q;

  assign pre_ok = !STRICT ||
    ((cnt >= PRE_LO) && (cnt <= PRE_HI));

  // Next-state and hold-stage requests from the raw byte.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    push    = 1'b0;
    flush   = 1'b0;
    first   = 1'b0;
    err     = 1'b0;
    perr    = 1'b0;
    take    = 1'b0;
    if (!rx_enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      flush   = (state == PAYLOAD);
    end else begin
      case (state)
        IDLE, PREAMBLE: begin
          state_n = PREAMBLE;
          if (rx_error) begin
            perr    = 1'b1;
            state_n = DROP;
          end else if (rx_data == PREAMBLE_BYTE) begin
            if (cnt != PRE_SAT) cnt_n = cnt + 1'b1;
          end else if (rx_data == SFD_BYTE) begin
            if (pre_ok) begin
              state_n = PAYLOAD;
              take    = 1'b1;
              len_n   = '0;
            end else begin
              perr    = 1'b1;
              state_n = DROP;
            end
          end else if (STRICT) begin
            perr    = 1'b1;
            state_n = DROP;
          end
        end
        PAYLOAD: begin
          if (len == LEN_MAX) begin
            flush   = 1'b1;
            err     = 1'b1;
            state_n = DROP;
          end else begin
            push  = 1'b1;
            first = (len == '0);
            err   = rx_error;
            len_n = len + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, status and the request pipeline flop.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      pre_len  <= '0;
      pre_err  <= 1'b0;
      sfd_wait <= 1'b1;
      push_q   <= 1'b0;
      flush_q  <= 1'b0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      len      <= len_n;
      pre_err  <= perr;
      sfd_wait <= (state_n != PAYLOAD);
      if (take) pre_len <= cnt;
      push_q   <= push;
      flush_q  <= flush;
      first_q  <= first;
      err_q    <= err;
      data_q   <= rx_data;
    end
  end

  rx_hold_stage u_hold (
    .rx_clk   (rx_clk),
    .reset_n  (reset_n),
    .push     (push_q),
    .flush    (flush_q),
    .first    (first_q),
    .err      (err_q),
    .data     (data_q),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_sof   (pl_sof),
    .pl_eof   (pl_eof),
    .pl_err   (pl_err)
  );

endmodule

// File: tb/tb_rx_sfd_framer.sv
// tb_rx_sfd_framer: directed vectors for the framer,
// second instance with MAX_FRAME=4 for truncation.
module tb_rx_sfd_framer;

  logic       rx_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       sfd_wait, pl_valid, pl_sof;
  logic       pl_eof, pl_err, pre_err;
  logic [7:0] pl_data;
  logic [4:0] pre_len;

  logic       sfd_wait_b, pl_valid_b, pl_sof_b;
  logic       pl_eof_b, pl_err_b, pre_err_b;
  logic [7:0] pl_data_b;
  logic [4:0] pre_len_b;

  always #5 rx_clk = ~rx_clk;

  rx_sfd_framer u_dut (
    .rx_clk    (rx_clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_enable (rx_enable),
    .rx_error  (rx_error),
    .sfd_wait  (sfd_wait),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_sof    (pl_sof),
    .pl_eof    (pl_eof),
    .pl_err    (pl_err),
    .pre_len   (pre_len),
    .pre_err   (pre_err)
  );

  rx_sfd_framer #(
    .MAX_FRAME (4),
    .LEN_W     (3)
  ) u_dut_b (
    .rx_clk    (rx_clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_enable (rx_enable),
    .rx_error  (rx_error),
    .sfd_wait  (sfd_wait_b),
    .pl_data   (pl_data_b),
    .pl_valid  (pl_valid_b),
    .pl_sof    (pl_sof_b),
    .pl_eof    (pl_eof_b),
    .pl_err    (pl_err_b),
    .pre_len   (pre_len_b),
    .pre_err   (pre_err_b)
  );

  int n_chk = 0;
  int n_ok  = 0;
  int perr_a = 0;
  int p0;

  logic [10:0] qa[$];
  logic [10:0] qb[$];
  logic [10:0] ex[$];
  logic [10:0] exb[$];
  logic [7:0]  tx[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  function automatic logic [10:0] bt(
    input logic e, input logic eo,
    input logic so, input logic [7:0] d);
    return {e, eo, so, d};
  endfunction

  always @(negedge rx_clk) begin
    if (pl_valid)
      qa.push_back({pl_err, pl_eof, pl_sof, pl_data});
    if (pl_valid_b)
      qb.push_back({pl_err_b, pl_eof_b,
                    pl_sof_b, pl_data_b});
    if (pre_err) perr_a++;
  end

  task automatic cyc(input logic en, input logic er,
                     input logic [7:0] d);
    rx_enable = en;
    rx_error  = er;
    rx_data   = d;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 8'hD5);
  endtask

  task automatic payload(input int errpos);
    for (int i = 0; i < tx.size(); i++)
      cyc(1'b1, i == errpos, tx[i]);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr;
    qa.delete();
    qb.delete();
    ex.delete();
    exb.delete();
    tx.delete();
    p0 = perr_a;
  endtask

  task automatic cmp_a(input string tag);
    chk({tag, "_n"}, qa.size(), ex.size());
    for (int i = 0; i < ex.size() && i < qa.size(); i++)
      chk($sformatf("%s_%0d", tag, i), qa[i], ex[i]);
  endtask

  task automatic cmp_b(input string tag);
    chk({tag, "_n"}, qb.size(), exb.size());
    for (int i = 0; i < exb.size() && i < qb.size(); i++)
      chk($sformatf("%s_%0d", tag, i), qb[i], exb[i]);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_wait", sfd_wait, 1);
    chk("rst_valid", pl_valid, 0);
    chk("rst_data", pl_data, 0);
    chk("rst_plen", pre_len, 0);
    chk("rst_perr", pre_err, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // basic frame with latency checks
    clr();
    preamble(7);
    chk("t1_wait", sfd_wait, 0);
    cyc(1'b1, 1'b0, 8'h01);
    chk("t1_v0", pl_valid, 0);
    cyc(1'b1, 1'b0, 8'h02);
    chk("t1_v1", pl_valid, 0);
    cyc(1'b1, 1'b0, 8'h03);
    chk("t1_v2", pl_valid, 1);
    chk("t1_d2", pl_data, 8'h01);
    chk("t1_s2", pl_sof, 1);
    cyc(1'b1, 1'b0, 8'h04);
    cyc(1'b0, 1'b0, 8'h00);
    chk("t1_wait_up", sfd_wait, 1);
    idle(3);
    ex.push_back(bt(0, 0, 1, 8'h01));
    ex.push_back(bt(0, 0, 0, 8'h02));
    ex.push_back(bt(0, 0, 0, 8'h03));
    ex.push_back(bt(0, 1, 0, 8'h04));
    cmp_a("t1");
    chk("t1_plen", pre_len, 7);
    chk("t1_perr", perr_a - p0, 0);

    // short preamble
    clr();
    preamble(3);
    tx.push_back(8'h11);
    tx.push_back(8'h22);
`ifdef RX_STRICT_PREAMBLE_EN
    chk("t2_wait", sfd_wait, 1);
    payload(-1);
    idle(3);
    cmp_a("t2");
    chk("t2_perr", perr_a - p0, 1);
    chk("t2_plen", pre_len, 7);
`else
    chk("t2_wait", sfd_wait, 0);
    payload(-1);
    idle(3);
    ex.push_back(bt(0, 0, 1, 8'h11));
    ex.push_back(bt(0, 1, 0, 8'h22));
    cmp_a("t2");
    chk("t2_perr", perr_a - p0, 0);
    chk("t2_plen", pre_len, 3);
`endif

    // rx_error mid-payload
    clr();
    preamble(7);
    tx.push_back(8'hAA);
    tx.push_back(8'hBB);
    tx.push_back(8'hCC);
    payload(1);
    idle(3);
    ex.push_back(bt(0, 0, 1, 8'hAA));
    ex.push_back(bt(0, 0, 0, 8'hBB));
    ex.push_back(bt(1, 1, 0, 8'hCC));
    cmp_a("t3");
    chk("t3_plen", pre_len, 7);

    // single byte, then zero payload
    clr();
    preamble(7);
    tx.push_back(8'h5A);
    payload(-1);
    idle(3);
    ex.push_back(bt(0, 1, 1, 8'h5A));
    cmp_a("t4a");
    clr();
    preamble(8);
    payload(-1);
    idle(3);
    cmp_a("t4b");
    chk("t4b_perr", perr_a - p0, 0);
    chk("t4b_plen", pre_len, 8);

    // truncation on the MAX_FRAME=4 instance
    clr();
    preamble(7);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'h10 + 8'(i));
      if (i == 4) begin
        chk("t5_wait_b", sfd_wait_b, 1);
        chk("t5_wait_a", sfd_wait, 0);
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    idle(3);
    for (int i = 0; i < 6; i++)
      ex.push_back(bt(0, i == 5, i == 0, 8'h10 + 8'(i)));
    for (int i = 0; i < 3; i++)
      exb.push_back(bt(0, 0, i == 0, 8'h10 + 8'(i)));
    exb.push_back(bt(1, 1, 0, 8'h13));
    cmp_a("t5a");
    cmp_b("t5b");
    chk("t5_plen_b", pre_len_b, 7);

    // reset mid-payload, then back-to-back frames
    clr();
    preamble(7);
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    chk("t6_pre_v", pl_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_v", pl_valid, 0);
    chk("t6_rst_d", pl_data, 0);
    chk("t6_rst_w", sfd_wait, 1);
    chk("t6_rst_l", pre_len, 0);
    rx_enable = 1'b0;
    idle(2);
    reset_n = 1'b1;
    clr();
    idle(3);
    chk("t6_no_eof", qa.size(), 0);
    preamble(7);
    tx.push_back(8'hA1);
    tx.push_back(8'hA2);
    payload(-1);
    tx.delete();
    preamble(7);
    tx.push_back(8'hB1);
    payload(-1);
    idle(3);
    ex.push_back(bt(0, 0, 1, 8'hA1));
    ex.push_back(bt(0, 1, 0, 8'hA2));
    ex.push_back(bt(0, 1, 1, 8'hB1));
    cmp_a("t6");
    chk("t6_perr", perr_a - p0, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
